if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of the IF/ID latch consumer (control unit and ID stage) and owns the PC/nPC register pair and the +4 adder. It runs a request/acknowledge fetch to instruction memory and loads the IF/ID register with the fetched word and its PC. It also handles hazard-unit stalls and branch/jump target redirects.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 40 ++++
 rtl/if_fetch_stage.sv | 139 +++++++++++++
 tb/tb_if_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// PC/nPC register pair with the +4 adder and the redirect mux.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_advance,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_npc
);

    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] w_target;

    assign w_target = align_word(i_target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + 32'd4;
        end else if (i_advance) begin
            if (i_redirect) begin
                r_pc  <= w_target;
                r_npc <= w_target + 32'd4;
            end else begin
                r_pc  <= r_npc;
                r_npc <= r_npc + 32'd4;
            end
        end
    end

    assign o_pc  = r_pc;
    assign o_npc = r_npc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: request/ack fetch FSM, hold buffer, pending redirect, IF/ID register.
// Define FETCH_DELAY_SLOT_EN to let the in-flight word complete as a branch delay slot.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              ta_valid_i,
    input  logic [31:0]       ta_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       ifid_instr_o,
    output logic [31:0]       ifid_pc_o,
    output logic              ifid_valid_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       npc_o
);

    fetch_state_e r_state, w_state_next;
    logic        r_run;
    logic [31:0] r_hold_buf, w_hold_next;
    logic        r_pending, w_pending_next;
    logic [31:0] r_pending_ta, w_pending_ta_next;
    logic [31:0] r_ifid_instr, w_ifid_instr_next;
    logic [31:0] r_ifid_pc, w_ifid_pc_next;
    logic        r_ifid_valid, w_ifid_valid_next;

    logic [31:0] w_pc;
    logic [31:0] w_npc;
    logic        w_is_fetch;
    logic        w_ack;
    logic        w_ta_valid;
    logic        w_advance;
    logic        w_redirect;
    logic        w_squash;
    logic [31:0] w_target;
    logic [31:0] w_word;

    // r_run gives the synchronous release: nothing is requested until the first edge after reset deasserts.
    assign w_is_fetch = (r_state == FETCH);
    assign imem_req_o = r_run && w_is_fetch;
    assign w_ack      = imem_req_o && imem_ack_i;
    assign w_ta_valid = r_run && ta_valid_i;
    assign w_advance  = !stall_i && (w_ack || (r_run && !w_is_fetch));
    assign w_redirect = w_ta_valid || r_pending;
    assign w_target   = w_ta_valid ? ta_i : r_pending_ta;
    assign w_word     = w_is_fetch ? imem_rdata_i : r_hold_buf;

`ifdef FETCH_DELAY_SLOT_EN
    assign w_squash = 1'b0;
`else
    assign w_squash = w_redirect;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .i_advance  (w_advance),
        .i_redirect (w_redirect),
        .i_target   (w_target),
        .o_pc       (w_pc),
        .o_npc      (w_npc)
    );

    always_comb begin
        w_state_next      = r_state;
        w_hold_next       = r_hold_buf;
        w_pending_next    = r_pending;
        w_pending_ta_next = r_pending_ta;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_valid_next = r_ifid_valid;

        if (w_advance) begin
            w_state_next   = FETCH;
            w_ifid_pc_next = w_pc;
            if (w_squash) begin
                w_ifid_instr_next = NOP_INSTR;
                w_ifid_valid_next = 1'b0;
            end else begin
                w_ifid_instr_next = w_word;
                w_ifid_valid_next = 1'b1;
            end
        end else if (w_ack) begin
            w_state_next = HOLD;
            w_hold_next  = imem_rdata_i;
        end else if (imem_req_o && !stall_i) begin
            w_ifid_instr_next = NOP_INSTR;
            w_ifid_pc_next    = w_pc;
            w_ifid_valid_next = 1'b0;
        end

        // A redirect is consumed by the advance; otherwise the newest target is kept.
        if (w_advance) begin
            w_pending_next = 1'b0;
        end else if (w_ta_valid) begin
            w_pending_next    = 1'b1;
            w_pending_ta_next = ta_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_run        <= 1'b0;
            r_hold_buf   <= NOP_INSTR;
            r_pending    <= 1'b0;
            r_pending_ta <= 32'h0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_run        <= 1'b1;
            r_hold_buf   <= w_hold_next;
            r_pending    <= w_pending_next;
            r_pending_ta <= w_pending_ta_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_valid <= w_ifid_valid_next;
        end
    end

    assign imem_addr_o  = w_pc[ADDR_W-1:0];
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_valid_o = r_ifid_valid;
    assign pc_o         = w_pc;
    assign npc_o        = w_npc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage; memory word at address a is 0xC000_0000 | a.
module tb_if_fetch_stage;

    localparam int unsigned ADDR_W = 9;
`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              stall = 1'b0;
    logic              ta_valid = 1'b0;
    logic [31:0]       ta_in = 32'h0;
    logic              ack = 1'b0;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc;
    logic              ifid_valid;
    logic [31:0]       pc;
    logic [31:0]       npc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign rdata = 32'hC000_0000 | {23'd0, addr};

    if_fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall),
        .ta_valid_i   (ta_valid),
        .ta_i         (ta_in),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .ifid_instr_o (ifid_instr),
        .ifid_pc_o    (ifid_pc),
        .ifid_valid_o (ifid_valid),
        .pc_o         (pc),
        .npc_o        (npc)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'hC000_0000 | {23'd0, a[8:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected IF/ID contents, compare after the edge.
    task automatic step(input logic st, input logic tv, input logic [31:0] ta, input logic ak,
                        input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        exp_t e;
        @(negedge clk);
        stall    = st;
        ta_valid = tv;
        ta_in    = ta;
        ack      = ak;
        sb_q.push_back('{instr: ei, pc: ep, valid: ev});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc", ifid_pc, e.pc);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
        $display("step st=%0b tv=%0b ta=%h ack=%0b -> ifid=%h/%h/%0b pc=%h", st, tv, ta, ak,
                 ifid_instr, ifid_pc, ifid_valid, pc);
    endtask

    task automatic release_reset();
        @(negedge clk);
        ta_valid = 1'b0;
        stall    = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req", {31'd0, req}, 32'd1);
        chk("rel_addr", {23'd0, addr}, 32'h0);
        chk("rel_pc", pc, 32'h0);
        chk("rel_npc", npc, 32'h4);
        chk("rel_valid", {31'd0, ifid_valid}, 32'd0);
    endtask

    initial begin
        ack = 1'b1;
        repeat (2) @(negedge clk);
        release_reset();

        // Back-to-back zero-wait fetches.
        step(0, 0, 0, 1, mw(32'h0), 32'h0, 1);
        step(0, 0, 0, 1, mw(32'h4), 32'h4, 1);
        step(0, 0, 0, 1, mw(32'h8), 32'h8, 1);

        // Reset asserted mid-cycle with ack high.
        #2;
        reset = 1'b0;
        #1;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_npc", npc, 32'h4);
        step(0, 0, 0, 1, 32'h0, 32'h0, 0);
        chk("rst_hold_req", {31'd0, req}, 32'd0);
        release_reset();

        step(0, 0, 0, 1, mw(32'h0), 32'h0, 1);

        // Two wait cycles on address 4.
        step(0, 0, 0, 0, 32'h0, 32'h4, 0);
        chk("wait_pc", pc, 32'h4);
        step(0, 0, 0, 0, 32'h0, 32'h4, 0);
        chk("wait_pc2", pc, 32'h4);
        step(0, 0, 0, 1, mw(32'h4), 32'h4, 1);

        // Stall on the ack of address 8 for three cycles.
        step(1, 0, 0, 1, mw(32'h4), 32'h4, 1);
        chk("hold_req", {31'd0, req}, 32'd0);
        step(1, 0, 0, 1, mw(32'h4), 32'h4, 1);
        step(1, 0, 0, 1, mw(32'h4), 32'h4, 1);
        chk("hold_pc", pc, 32'h8);
        step(0, 0, 0, 1, mw(32'h8), 32'h8, 1);
        chk("post_hold_req", {31'd0, req}, 32'd1);
        chk("post_hold_addr", {23'd0, addr}, 32'hC);

        // Redirect taken while fetching 12.
        step(0, 1, 32'h43, 1, DS ? mw(32'hC) : 32'h0, 32'hC, DS);
        chk("br_pc", pc, 32'h40);
        chk("br_npc", npc, 32'h44);
        step(0, 0, 0, 1, mw(32'h40), 32'h40, 1);

        // Redirect arrives with a stall: held as pending, consumed on HOLD release.
        step(1, 1, 32'h100, 1, mw(32'h40), 32'h40, 1);
        chk("stall_br_pc", pc, 32'h44);
        step(0, 0, 0, 1, DS ? mw(32'h44) : 32'h0, 32'h44, DS);
        chk("pend_pc", pc, 32'h100);
        chk("pend_req", {31'd0, req}, 32'd1);

        // Redirect to the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 1, DS ? mw(32'h100) : 32'h0, 32'h100, DS);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0);
        chk("wrap_addr", {23'd0, addr}, 32'h1FC);
        step(0, 0, 0, 1, mw(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
        chk("wrap_pc2", pc, 32'h0);

        // Redirect during a wait cycle stays pending until the ack.
        step(0, 1, 32'h80, 0, 32'h0, 32'h0, 0);
        chk("wait_br_pc", pc, 32'h0);
        step(0, 0, 0, 1, DS ? mw(32'h0) : 32'h0, 32'h0, DS);
        chk("wait_br_pc2", pc, 32'h80);
        step(0, 0, 0, 1, mw(32'h80), 32'h80, 1);

        // A second target while pending overwrites the first.
        step(0, 1, 32'h200, 0, 32'h0, 32'h84, 0);
        step(0, 1, 32'h300, 0, 32'h0, 32'h84, 0);
        step(0, 0, 0, 1, DS ? mw(32'h84) : 32'h0, 32'h84, DS);
        chk("ovr_pc", pc, 32'h300);
        step(0, 0, 0, 1, mw(32'h300), 32'h300, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
